vx_tc_smem_responder: RTL

Responder (slave) end of the tensor-core shared-memory bus. The tensor core uses this bus to fetch A/B operand tiles. The block accepts tagged read requests, issues them to a fixed-latency shared-memory SRAM read port, and returns in-order tagged responses. A response buffer absorbs backpressure, and a credit counter guarantees that no read data is ever dropped. One instance sits behind each of the tensor core's A and B request ports.

---
 rtl/vx_tc_smem_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vx_tc_smem_responder.sv
// vx_tc_smem_responder
// Responder end of the tensor-core shared-memory bus. Accepts tagged reads,
// issues them to a fixed-latency SRAM read port, and returns in-order tagged
// responses through a response FIFO. A credit counter keeps requests in flight
// plus buffered responses within the FIFO depth, so read data is never dropped.
// Optional feature: define TC_SMEM_RSP_BYPASS_EN to present SRAM data
// combinationally when the FIFO is empty (one cycle lower latency).
module vx_tc_smem_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int TAG_WIDTH       = 4,
  parameter int WORD_ADDR_WIDTH = 10,
  parameter int READ_LATENCY    = 2,
  parameter int RSP_QUEUE_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  output logic                       sram_rd_en,
  output logic [WORD_ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0]      sram_rd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TAG_WIDTH-1:0]       rsp_tag,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       misalign_err
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W = $clog2(RSP_QUEUE_DEPTH + 1);
  localparam int PTR_W = (RSP_QUEUE_DEPTH > 1) ? $clog2(RSP_QUEUE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_QUEUE_DEPTH - 1);

  logic [CNT_W-1:0] outstanding;
  logic             req_fire;
  logic             rsp_fire;

  // Tag pipeline: stage index 0 is the cycle after the SRAM read enable
  logic [READ_LATENCY-1:0] vld_p;
  logic [TAG_WIDTH-1:0]    tag_p [READ_LATENCY];
  logic                    pipe_vld;
  logic [TAG_WIDTH-1:0]    pipe_tag;

  // Response FIFO
  logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [RSP_QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_push;
  logic                  fifo_pop;

  // Upper address bits beyond the SRAM word index are intentionally ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:OFF_W+WORD_ADDR_WIDTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check: issue only while a FIFO slot is reserved for the response
  assign req_ready    = !reset && (outstanding < DEPTH_C);
  assign req_fire     = req_valid && req_ready;
  assign sram_rd_en   = req_fire;
  assign sram_rd_addr = req_addr[OFF_W +: WORD_ADDR_WIDTH];

  assign pipe_vld   = vld_p[READ_LATENCY-1];
  assign pipe_tag   = tag_p[READ_LATENCY-1];
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);

  // Response presentation and FIFO push/pop selection
  always_comb begin
    rsp_valid = !fifo_empty;
    rsp_tag   = fifo_tag[rd_ptr];
    rsp_data  = fifo_data[rd_ptr];
    fifo_push = pipe_vld;
`ifdef TC_SMEM_RSP_BYPASS_EN
    if (fifo_empty && pipe_vld) begin
      rsp_valid = 1'b1;
      rsp_tag   = pipe_tag;
      rsp_data  = sram_rd_data;
      fifo_push = !rsp_ready;
    end
`endif
    rsp_fire = rsp_valid && rsp_ready;
    fifo_pop = rsp_fire && !fifo_empty;
  end

  // Tag pipeline valid bits (control, reset)
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= req_fire;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Tag pipeline payload (data, no reset)
  always_ff @(posedge clk) begin
    tag_p[0] <= req_tag;
    for (int i = 1; i < READ_LATENCY; i++) tag_p[i] <= tag_p[i-1];
  end

  // FIFO storage write (data, no reset)
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_tag[wr_ptr]  <= pipe_tag;
      fifo_data[wr_ptr] <= sram_rd_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credit counter: requests in the pipeline plus responses held in the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky misaligned-address flag; the request is still served truncated
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (req_fire && (|req_addr[OFF_W-1:0])) begin
      misalign_err <= 1'b1;
    end
  end

  // The credit rule makes a push into a full FIFO impossible
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fifo_push && fifo_full))
        else $error("vx_tc_smem_responder: response FIFO push while full");
    end
  end

endmodule
